hazard_forward_ctrl: RTL and testbench

- Parametrised successor to the pipeline forwarding logic for the 5-stage RISC-V core.
- Tracks the E, M and W destination/source register fields internally. It needs only decode-stage operands plus pipeline events.
- Generates per-operand forwarding selects, load-use stalls, branch flushes and data-memory-busy freezes.
- Keeps saturating stall/flush performance counters.
- Sits beside the datapath and drives all pipeline-register enables and clears.

---
 rtl/hazard_forward_ctrl_if.sv | 36 +++
 rtl/hazard_forward_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline hazard/forwarding control bundle: decode-stage operands and pipeline
// events in, forwarding selects, pipeline-register enables/clears and counters out.
interface hazard_forward_ctrl_if #(
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
) ();
    logic [NSRC*AW-1:0] rs_d;
    logic [AW-1:0]      rd_d;
    logic               regwrite_d;
    logic               memread_d;
    logic               pcsrc_e;
    logic               mem_busy;
    logic [NSRC*2-1:0]  fwd_e;
    logic               stall_f;
    logic               stall_d;
    logic               flush_d;
    logic               flush_e;
    logic               stall_e;
    logic               stall_m;
    logic               bubble_w;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    modport master (
        output rs_d, rd_d, regwrite_d, memread_d, pcsrc_e, mem_busy,
        input  fwd_e, stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, bubble_w,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_d, rd_d, regwrite_d, memread_d, pcsrc_e, mem_busy,
        output fwd_e, stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, bubble_w,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit for the 5-stage core: shadows the E/M/W register fields itself and
// derives forwarding, load-use stalls, branch flushes and memory-busy freezes.
module hazard_forward_ctrl #(
    parameter int AW    = 5,
    parameter int NSRC  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_forward_ctrl_if.slave bus
);
    logic [AW-1:0]    rs_e_q [NSRC];
    logic [AW-1:0]    rs_e_d [NSRC];
    logic [AW-1:0]    rd_e_q, rd_e_d, rd_m_q, rd_m_d, rd_w_q, rd_w_d;
    logic             rw_e_q, rw_e_d, ld_e_q, ld_e_d;
    logic             rw_m_q, rw_m_d, rw_w_q, rw_w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    logic [NSRC-1:0]  lu_hit;
    logic             lu;
    logic             stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, bubble_w;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        logic [AW-1:0] rs_dec;
        logic [1:0]    fwd_sel;

        assign rs_dec      = bus.rs_d[gi*AW +: AW];
        assign lu_hit[gi]  = (rs_dec == rd_e_q);

        // M holds the younger result, so it wins when both stages match.
        always_comb begin
            fwd_sel = 2'b00;
            if (rw_m_q && (rd_m_q != '0) && (rd_m_q == rs_e_q[gi])) begin
                fwd_sel = 2'b10;
            end else if (rw_w_q && (rd_w_q != '0) && (rd_w_q == rs_e_q[gi])) begin
                fwd_sel = 2'b01;
            end
        end

        assign bus.fwd_e[gi*2 +: 2] = fwd_sel;
    end

    assign lu = ld_e_q && (rd_e_q != '0) && (|lu_hit);

    always_comb begin
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        stall_e  = 1'b0;
        stall_m  = 1'b0;
        bubble_w = 1'b0;
        if (bus.mem_busy) begin
            // A taken branch waits: the datapath keeps pcsrc_e asserted until release.
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else if (bus.pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        rs_e_d      = rs_e_q;
        rd_e_d      = rd_e_q;
        rw_e_d      = rw_e_q;
        ld_e_d      = ld_e_q;
        rd_m_d      = rd_m_q;
        rw_m_d      = rw_m_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (!stall_e) begin
            if (flush_e) begin
                for (int k = 0; k < NSRC; k++) rs_e_d[k] = '0;
                rd_e_d = '0;
                rw_e_d = 1'b0;
                ld_e_d = 1'b0;
            end else begin
                for (int k = 0; k < NSRC; k++) rs_e_d[k] = bus.rs_d[k*AW +: AW];
                rd_e_d = bus.rd_d;
                rw_e_d = bus.regwrite_d;
                ld_e_d = bus.memread_d;
            end
        end

        if (!stall_m) begin
            rd_m_d = rd_e_q;
            rw_m_d = rw_e_q;
        end

        rd_w_d = bubble_w ? '0 : rd_m_q;
        rw_w_d = bubble_w ? 1'b0 : rw_m_q;

        if (stall_d && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (flush_d && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NSRC; k++) rs_e_q[k] <= '0;
            rd_e_q      <= '0;
            rw_e_q      <= 1'b0;
            ld_e_q      <= 1'b0;
            rd_m_q      <= '0;
            rw_m_q      <= 1'b0;
            rd_w_q      <= '0;
            rw_w_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            rs_e_q      <= rs_e_d;
            rd_e_q      <= rd_e_d;
            rw_e_q      <= rw_e_d;
            ld_e_q      <= ld_e_d;
            rd_m_q      <= rd_m_d;
            rw_m_q      <= rw_m_d;
            rd_w_q      <= rd_w_d;
            rw_w_q      <= rw_w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_f   = stall_f;
    assign bus.stall_d   = stall_d;
    assign bus.flush_d   = flush_d;
    assign bus.flush_e   = flush_e;
    assign bus.stall_e   = stall_e;
    assign bus.stall_m   = stall_m;
    assign bus.bubble_w  = bubble_w;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: three configurations (default, 4-bit counters,
// three 6-bit operands) driven cycle by cycle from hand-derived stimulus tables.
module tb_hazard_forward_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.AW(5), .NSRC(2), .CNT_W(16)) if_a ();
    hazard_forward_ctrl_if #(.AW(5), .NSRC(2), .CNT_W(4))  if_b ();
    hazard_forward_ctrl_if #(.AW(6), .NSRC(3), .CNT_W(16)) if_c ();

    hazard_forward_ctrl #(.AW(5), .NSRC(2), .CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    hazard_forward_ctrl #(.AW(5), .NSRC(2), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(if_b));
    hazard_forward_ctrl #(.AW(6), .NSRC(3), .CNT_W(16)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    // control vector order: {stall_f, stall_d, flush_d, flush_e, stall_e, stall_m, bubble_w}
    localparam int C0     = 'b0000000;
    localparam int C_LU   = 'b1101000;
    localparam int C_BR   = 'b0011000;
    localparam int C_BUSY = 'b1100111;

    typedef struct packed {
        logic       chk;
        logic       rst;
        logic [5:0] rs2;
        logic [5:0] rs1;
        logic [5:0] rs0;
        logic [5:0] rd;
        logic       rw;
        logic       ld;
        logic       pc;
        logic       busy;
        logic [5:0] fwd;
        logic [6:0] ctl;
    } row_t;

    row_t sb[$];

    function automatic row_t mk(input int chk, input int rst, input int rs2, input int rs1,
                                input int rs0, input int rd, input int rw, input int ld,
                                input int pc, input int busy, input int fwd, input int ctl);
        row_t r;
        r.chk  = chk[0];
        r.rst  = rst[0];
        r.rs2  = 6'(rs2);
        r.rs1  = 6'(rs1);
        r.rs0  = 6'(rs0);
        r.rd   = 6'(rd);
        r.rw   = rw[0];
        r.ld   = ld[0];
        r.pc   = pc[0];
        r.busy = busy[0];
        r.fwd  = 6'(fwd);
        r.ctl  = 7'(ctl);
        return r;
    endfunction

    function automatic logic [12:0] obs(input int sel);
        case (sel)
            0: return {2'b00, if_a.fwd_e, if_a.stall_f, if_a.stall_d, if_a.flush_d,
                       if_a.flush_e, if_a.stall_e, if_a.stall_m, if_a.bubble_w};
            1: return {2'b00, if_b.fwd_e, if_b.stall_f, if_b.stall_d, if_b.flush_d,
                       if_b.flush_e, if_b.stall_e, if_b.stall_m, if_b.bubble_w};
            default: return {if_c.fwd_e, if_c.stall_f, if_c.stall_d, if_c.flush_d,
                             if_c.flush_e, if_c.stall_e, if_c.stall_m, if_c.bubble_w};
        endcase
    endfunction

    task automatic drive_row(input int sel, input row_t r);
        @(posedge clk);
        #1;
        reset = r.rst;
        case (sel)
            0: begin
                if_a.rs_d = {r.rs1[4:0], r.rs0[4:0]};
                if_a.rd_d = r.rd[4:0];
                if_a.regwrite_d = r.rw;
                if_a.memread_d  = r.ld;
                if_a.pcsrc_e    = r.pc;
                if_a.mem_busy   = r.busy;
            end
            1: begin
                if_b.rs_d = {r.rs1[4:0], r.rs0[4:0]};
                if_b.rd_d = r.rd[4:0];
                if_b.regwrite_d = r.rw;
                if_b.memread_d  = r.ld;
                if_b.pcsrc_e    = r.pc;
                if_b.mem_busy   = r.busy;
            end
            default: begin
                if_c.rs_d = {r.rs2, r.rs1, r.rs0};
                if_c.rd_d = r.rd;
                if_c.regwrite_d = r.rw;
                if_c.memread_d  = r.ld;
                if_c.pcsrc_e    = r.pc;
                if_c.mem_busy   = r.busy;
            end
        endcase
    endtask

    task automatic test_reset();
        row_t rows[2];
        row_t e;
        logic [12:0] got;
        rows = '{mk(0,1, 0,0,0, 0, 0,0,0,0, 0, C0),
                 mk(1,0, 0,0,0, 0, 0,0,0,0, 0, C0)};
        for (int k = 0; k < 2; k++) begin
            drive_row(0, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(0);
            if (e.chk) begin
                total++;
                if (got !== {e.fwd, e.ctl}) begin
                    bad++;
                    $display("FAIL reset[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
                end
            end
        end
        total++;
        if (if_a.stall_cnt !== 16'd0 || if_a.flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_chain();
        row_t rows[15];
        row_t e;
        logic [12:0] got;
        rows = '{mk(1,0, 0,0,0,  5, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,5,  6, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,5,0,  7, 0,0,0,0, 'b000010, C0),
                 mk(1,0, 0,0,0,  0, 1,0,0,0, 'b000100, C0),
                 mk(1,0, 0,0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  9, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  9, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,9,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  0, 0,0,0,0, 'b000010, C0),
                 mk(1,0, 0,0,0, 11, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,11, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,11, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  0, 0,0,0,0, 'b000000, C0)};
        for (int k = 0; k < 15; k++) begin
            drive_row(0, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(0);
            total++;
            if (got !== {e.fwd, e.ctl}) begin
                bad++;
                $display("FAIL alu_chain[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
            end
        end
        total++;
        if (if_a.stall_cnt !== 16'd0 || if_a.flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL alu_chain_counters got=%0d/%0d want=0/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        $display("test_alu_chain done");
    endtask

    task automatic test_load_use();
        row_t rows[5];
        row_t e;
        logic [12:0] got;
        rows = '{mk(0,1, 0,0,0, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0, 7, 1,1,0,0, 'b000000, C0),
                 mk(1,0, 0,7,0, 8, 1,0,0,0, 'b000000, C_LU),
                 mk(1,0, 0,7,0, 8, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0, 0, 0,0,0,0, 'b000100, C0)};
        for (int k = 0; k < 5; k++) begin
            drive_row(0, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(0);
            if (e.chk) begin
                total++;
                if (got !== {e.fwd, e.ctl}) begin
                    bad++;
                    $display("FAIL load_use[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
                end
            end
        end
        total++;
        if (if_a.stall_cnt !== 16'd1 || if_a.flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL load_use_counters got=%0d/%0d want=1/0", if_a.stall_cnt, if_a.flush_cnt);
        end
        $display("test_load_use done");
    endtask

    task automatic test_branch();
        row_t rows[5];
        row_t e;
        logic [12:0] got;
        rows = '{mk(1,0, 0,0,0,  12, 1,1,0,0, 'b000000, C0),
                 mk(1,0, 0,0,12, 0,  0,0,1,0, 'b000000, C_BR),
                 mk(1,0, 0,0,0,  0,  0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0,  0,  0,0,1,0, 'b000000, C_BR),
                 mk(1,0, 0,0,0,  0,  0,0,0,0, 'b000000, C0)};
        for (int k = 0; k < 5; k++) begin
            drive_row(0, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(0);
            total++;
            if (got !== {e.fwd, e.ctl}) begin
                bad++;
                $display("FAIL branch[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
            end
        end
        total++;
        if (if_a.stall_cnt !== 16'd1 || if_a.flush_cnt !== 16'd2) begin
            bad++;
            $display("FAIL branch_counters got=%0d/%0d want=1/2", if_a.stall_cnt, if_a.flush_cnt);
        end
        $display("test_branch done");
    endtask

    task automatic test_mem_busy();
        row_t rows[12];
        row_t e;
        logic [12:0] got;
        rows = '{mk(0,1, 0,0,0, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0, 9, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,9, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,0,0, 0, 0,0,0,1, 'b000010, C_BUSY),
                 mk(1,0, 0,0,0, 0, 0,0,1,1, 'b000010, C_BUSY),
                 mk(1,0, 0,0,0, 0, 0,0,1,1, 'b000010, C_BUSY),
                 mk(1,0, 0,0,0, 0, 0,0,1,0, 'b000010, C_BR),
                 mk(1,0, 0,0,0, 9, 1,0,0,0, 'b000000, C0),
                 mk(1,0, 0,9,0, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0,9,0, 0, 0,0,0,1, 'b001000, C_BUSY),
                 mk(1,0, 0,9,0, 0, 0,0,0,0, 'b001000, C0),
                 mk(1,0, 0,0,0, 0, 0,0,0,0, 'b000100, C0)};
        for (int k = 0; k < 12; k++) begin
            drive_row(0, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(0);
            if (e.chk) begin
                total++;
                if (got !== {e.fwd, e.ctl}) begin
                    bad++;
                    $display("FAIL mem_busy[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
                end
            end
        end
        total++;
        if (if_a.stall_cnt !== 16'd4 || if_a.flush_cnt !== 16'd1) begin
            bad++;
            $display("FAIL mem_busy_counters got=%0d/%0d want=4/1", if_a.stall_cnt, if_a.flush_cnt);
        end
        $display("test_mem_busy done");
    endtask

    task automatic test_saturation();
        row_t r;
        row_t e;
        logic [12:0] got;
        for (int k = 0; k < 22; k++) begin
            if (k == 0)       r = mk(0,1, 0,0,0, 0, 0,0,0,0, 0, C0);
            else if (k <= 20) r = mk(1,0, 0,0,0, 0, 0,0,0,1, 0, C_BUSY);
            else              r = mk(1,0, 0,0,0, 0, 0,0,0,0, 0, C0);
            drive_row(1, r);
            sb.push_back(r);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(1);
            if (e.chk) begin
                total++;
                if (got !== {e.fwd, e.ctl}) begin
                    bad++;
                    $display("FAIL saturation[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
                end
            end
        end
        total++;
        if (if_b.stall_cnt !== 4'd15 || if_b.flush_cnt !== 4'd0) begin
            bad++;
            $display("FAIL saturation_counters got=%0d/%0d want=15/0", if_b.stall_cnt, if_b.flush_cnt);
        end
        $display("test_saturation done");
    endtask

    task automatic test_nsrc3_reset();
        row_t rows[9];
        row_t e;
        logic [12:0] got;
        rows = '{mk(0,1, 0, 0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0, 0,0,  33,1,0,0,0, 'b000000, C0),
                 mk(1,0, 0, 0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 33,0,0,  0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0, 0,0,  0, 0,0,0,0, 'b010000, C0),
                 mk(1,0, 0, 0,0,  40,1,1,0,0, 'b000000, C0),
                 mk(1,1, 0, 0,40, 0, 0,0,0,0, 'b000000, C_LU),
                 mk(1,0, 0, 0,40, 0, 0,0,0,0, 'b000000, C0),
                 mk(1,0, 0, 0,0,  0, 0,0,0,0, 'b000000, C0)};
        for (int k = 0; k < 9; k++) begin
            drive_row(2, rows[k]);
            sb.push_back(rows[k]);
            @(negedge clk);
            e = sb.pop_front();
            got = obs(2);
            if (e.chk) begin
                total++;
                if (got !== {e.fwd, e.ctl}) begin
                    bad++;
                    $display("FAIL nsrc3[%0d] fwd_ctl got=%b want=%b", k, got, {e.fwd, e.ctl});
                end
            end
        end
        total++;
        if (if_c.stall_cnt !== 16'd0 || if_c.flush_cnt !== 16'd0) begin
            bad++;
            $display("FAIL nsrc3_counters got=%0d/%0d want=0/0", if_c.stall_cnt, if_c.flush_cnt);
        end
        $display("test_nsrc3_reset done");
    endtask

    initial begin
        reset = 1'b1;
        if_a.rs_d = '0; if_a.rd_d = '0; if_a.regwrite_d = 1'b0;
        if_a.memread_d = 1'b0; if_a.pcsrc_e = 1'b0; if_a.mem_busy = 1'b0;
        if_b.rs_d = '0; if_b.rd_d = '0; if_b.regwrite_d = 1'b0;
        if_b.memread_d = 1'b0; if_b.pcsrc_e = 1'b0; if_b.mem_busy = 1'b0;
        if_c.rs_d = '0; if_c.rd_d = '0; if_c.regwrite_d = 1'b0;
        if_c.memread_d = 1'b0; if_c.pcsrc_e = 1'b0; if_c.mem_busy = 1'b0;

        test_reset();
        test_alu_chain();
        test_load_use();
        test_branch();
        test_mem_busy();
        test_saturation();
        test_nsrc3_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
